// File: rtl/kyber_model_pkg.sv
// Shared mode codes, FSM encoding and width/beat helpers for the Kyber behavioural core model.
package kyber_model_pkg;

    localparam logic [1:0] MODE_KEYGEN  = 2'b00;
    localparam logic [1:0] MODE_ENCAPS  = 2'b01;
    localparam logic [1:0] MODE_DECAPS  = 2'b10;
    localparam logic [1:0] MODE_ILLEGAL = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_FILL = 2'b01;
    localparam logic [1:0] ST_WAIT = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    // x^256 + x^10 + x^5 + x^2 + 1 in right-shifting Galois form
    localparam logic [255:0] LFSR_TAPS = {1'b1, 245'd0, 1'b1, 4'd0, 1'b1, 2'd0, 1'b1, 1'b0};

    function automatic int pk_w(input int k);
        return 3072 * k + 256;
    endfunction

    function automatic int sk_w(input int k);
        return 3072 * k;
    endfunction

    function automatic int c_w(input int k, input int du, input int dv);
        return 256 * (du * k + dv);
    endfunction

    function automatic int keygen_beats(input int k);
        return 12 * k + 1;
    endfunction

    function automatic int encaps_beats(input int k, input int du, input int dv);
        return du * k + dv;
    endfunction

    // Counter is shared by the fill beats and the extra-latency wait.
    function automatic int cnt_w(input int k, input int lat);
        int bw;
        int lw;
        bw = $clog2(12 * k + 2);
        lw = $clog2(lat + 2);
        return (bw > lw) ? bw : lw;
    endfunction

endpackage

// File: rtl/kyber_word_gen.sv
// Combinational beat-word generator for the fill phase.
// With KYBER_MODEL_LFSR_EN defined it also owns the 256-bit keygen LFSR.
module kyber_word_gen
    import kyber_model_pkg::*;
#(
    parameter int CW = 5
) (
`ifdef KYBER_MODEL_LFSR_EN
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          step,
    input  logic [255:0]  seed,
`else
    input  logic [255:0]  coin,
`endif
    input  logic [1:0]    mode,
    input  logic [255:0]  msg,
    input  logic [CW-1:0] w,
    output logic [255:0]  word
);

    logic [255:0] idx_s;

`ifdef KYBER_MODEL_LFSR_EN
    logic [255:0] lfsr_r;

    // Seed on acceptance (a zero seed would lock up, so it maps to 1), then one step per beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= 256'd1;
        end else if (load) begin
            lfsr_r <= (seed == 256'd0) ? 256'd1 : seed;
        end else if (step) begin
            lfsr_r <= (lfsr_r >> 1) ^ (lfsr_r[0] ? LFSR_TAPS : 256'd0);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end
`endif

    // Beat word: keygen source or message, tagged with the low byte of the beat index.
    always_comb begin
        idx_s = {248'd0, 8'(w)};
`ifdef KYBER_MODEL_LFSR_EN
        if (mode == MODE_KEYGEN) begin
            word = lfsr_r;
        end else begin
            word = msg ^ idx_s;
        end
`else
        if (mode == MODE_KEYGEN) begin
            word = coin ^ idx_s;
        end else begin
            word = msg ^ idx_s;
        end
`endif
    end

endmodule

// File: rtl/kyber_model_core.sv
// Cycle-accurate behavioural stand-in for a Kyber KEM core (keygen/encaps/decaps).
// Define KYBER_MODEL_LFSR_EN to source keygen words from a 256-bit Galois LFSR.
module kyber_model_core
    import kyber_model_pkg::*;
#(
    parameter int K         = 2,
    parameter int DU        = 10,
    parameter int DV        = 4,
    parameter int EXTRA_LAT = 4,
    localparam int PK_W     = pk_w(K),
    localparam int SK_W     = sk_w(K),
    localparam int C_W      = c_w(K, DU, DV)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      mode,
    input  logic [255:0]    random_coin,
    input  logic [255:0]    m_in,
    input  logic [PK_W-1:0] pk_in,
    input  logic [SK_W-1:0] sk_in,
    input  logic [C_W-1:0]  c_in,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [255:0]    m_out,
    output logic [PK_W-1:0] pk_out,
    output logic [SK_W-1:0] sk_out,
    output logic [C_W-1:0]  c_out
);

    localparam int CW = cnt_w(K, EXTRA_LAT);
    localparam logic [CW-1:0] KG_LAST   = CW'(keygen_beats(K) - 1);
    localparam logic [CW-1:0] EN_LAST   = CW'(encaps_beats(K, DU, DV) - 1);
    localparam logic [CW-1:0] SK_WORDS  = CW'(12 * K);
    localparam logic [CW-1:0] WAIT_LAST = CW'((EXTRA_LAT > 0) ? EXTRA_LAT - 1 : 0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [1:0]    state_r;
    logic [1:0]    mode_r;
    logic [CW-1:0] w_r;
    logic [255:0]  msg_r;
    logic [CW-1:0] last_s;
    logic [255:0]  word_s;
    logic          accept_s;

    assign accept_s = (state_r == ST_IDLE) && start;

    // Final beat index of the fill phase for the latched operation.
    always_comb begin
        case (mode_r)
            MODE_KEYGEN: last_s = KG_LAST;
            MODE_ENCAPS: last_s = EN_LAST;
            default:     last_s = {CW{1'b0}};
        endcase
    end

`ifdef KYBER_MODEL_LFSR_EN
    kyber_word_gen #(.CW(CW)) u_word_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept_s),
        .step  (state_r == ST_FILL),
        .seed  (random_coin),
        .mode  (mode_r),
        .msg   (msg_r),
        .w     (w_r),
        .word  (word_s)
    );
`else
    logic [255:0] coin_r;

    // Seed is latched at acceptance so the source may change during the fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coin_r <= 256'd0;
        end else if (accept_s) begin
            coin_r <= random_coin;
        end else begin
            coin_r <= coin_r;
        end
    end

    kyber_word_gen #(.CW(CW)) u_word_gen (
        .coin  (coin_r),
        .mode  (mode_r),
        .msg   (msg_r),
        .w     (w_r),
        .word  (word_s)
    );
`endif

    // Operation sequencer: accept, fill one beat per cycle, optional wait, done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            mode_r  <= MODE_KEYGEN;
            w_r     <= {CW{1'b0}};
            msg_r   <= 256'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            m_out   <= 256'd0;
            pk_out  <= {PK_W{1'b0}};
            sk_out  <= {SK_W{1'b0}};
            c_out   <= {C_W{1'b0}};
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        mode_r <= mode;
                        msg_r  <= m_in;
                        w_r    <= {CW{1'b0}};
                        err    <= 1'b0;
                        case (mode)
                            MODE_KEYGEN: begin
                                m_out <= m_in;
                                c_out <= c_in;
                            end
                            MODE_ENCAPS: begin
                                pk_out <= pk_in;
                                sk_out <= sk_in;
                                m_out  <= m_in;
                            end
                            MODE_DECAPS: begin
                                pk_out <= pk_in;
                                sk_out <= sk_in;
                                c_out  <= c_in;
                            end
                            default: ;
                        endcase
                        state_r <= (mode == MODE_ILLEGAL) ? ST_DONE : ST_FILL;
                        busy    <= (mode != MODE_ILLEGAL);
                    end
                end
                ST_FILL: begin
                    case (mode_r)
                        MODE_KEYGEN: begin
                            pk_out[{w_r, 8'd0} +: 256] <= word_s;
                            if (w_r < SK_WORDS) begin
                                sk_out[{w_r, 8'd0} +: 256] <= ~word_s;
                            end
                        end
                        MODE_ENCAPS: c_out[{w_r, 8'd0} +: 256] <= word_s;
                        MODE_DECAPS: m_out <= c_in[C_W-1 -: 256];
                        default: ;
                    endcase
                    if (w_r == last_s) begin
                        w_r <= {CW{1'b0}};
                        if (EXTRA_LAT == 0) begin
                            state_r <= ST_DONE;
                            busy    <= 1'b0;
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end else begin
                        w_r <= w_r + CNT_ONE;
                    end
                end
                ST_WAIT: begin
                    if (w_r == WAIT_LAST) begin
                        state_r <= ST_DONE;
                        busy    <= 1'b0;
                    end else begin
                        w_r <= w_r + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b1;
                    err     <= (mode_r == MODE_ILLEGAL);
                    state_r <= ST_IDLE;
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kyber_model_core.sv
// Self-checking bench for kyber_model_core: directed table, random ops against a reference model,
// start-while-busy, mid-operation reset and a K=4/EXTRA_LAT=0 instance.
module tb_kyber_model_core;

    localparam int KA = 2, DUA = 10, DVA = 4, LA = 4;
    localparam int PKA = 3072 * KA + 256, SKA = 3072 * KA, CA = 256 * (DUA * KA + DVA);
    localparam int KB = 4, DUB = 11, DVB = 5, LB = 0;
    localparam int PKB = 3072 * KB + 256, SKB = 3072 * KB, CB = 12544;
    localparam int NB = 49;

    localparam logic [1:0] KG = 2'b00, EN = 2'b01, DE = 2'b10, IL = 2'b11;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic           start_a, busy_a, done_a, err_a;
    logic [1:0]     mode_a;
    logic [255:0]   coin_a, m_a, m_out_a;
    logic [PKA-1:0] pk_a, pk_out_a;
    logic [SKA-1:0] sk_a, sk_out_a;
    logic [CA-1:0]  c_a, c_out_a;

    logic           start_b, busy_b, done_b, err_b;
    logic [1:0]     mode_b;
    logic [255:0]   coin_b, m_b, m_out_b;
    logic [PKB-1:0] pk_b, pk_out_b;
    logic [SKB-1:0] sk_b, sk_out_b;
    logic [CB-1:0]  c_b, c_out_b;

    kyber_model_core #(.K(KA), .DU(DUA), .DV(DVA), .EXTRA_LAT(LA)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode_a), .random_coin(coin_a),
        .m_in(m_a), .pk_in(pk_a), .sk_in(sk_a), .c_in(c_a), .busy(busy_a), .done(done_a),
        .err(err_a), .m_out(m_out_a), .pk_out(pk_out_a), .sk_out(sk_out_a), .c_out(c_out_a)
    );

    kyber_model_core #(.K(KB), .DU(DUB), .DV(DVB), .EXTRA_LAT(LB)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b), .random_coin(coin_b),
        .m_in(m_b), .pk_in(pk_b), .sk_in(sk_b), .c_in(c_b), .busy(busy_b), .done(done_b),
        .err(err_b), .m_out(m_out_b), .pk_out(pk_out_b), .sk_out(sk_out_b), .c_out(c_out_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model of dut_a's visible output registers.
    logic [PKA-1:0] e_pk;
    logic [SKA-1:0] e_sk;
    logic [CA-1:0]  e_c;
    logic [255:0]   e_m;

    typedef struct {
        logic [1:0]   md;
        logic [255:0] cn;
        logic [255:0] mm;
        logic [255:0] ctop;
        int           lat;
        bit           err;
    } vec_t;
    vec_t tbl [5];

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic int lat_a(input logic [1:0] md);
        case (md)
            KG:      return 12 * KA + 1 + LA + 1;
            EN:      return DUA * KA + DVA + LA + 1;
            DE:      return 1 + LA + 1;
            default: return 1;
        endcase
    endfunction

    task automatic chk_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk256(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [12543:0] act, input logic [12543:0] exp,
                           input int words);
        int bw;
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            bw = 0;
            for (int i = words - 1; i >= 0; i--)
                if (act[i*256 +: 256] !== exp[i*256 +: 256]) bw = i;
            $display("FAIL %s word %0d: got %h expected %h", nm, bw, act[bw*256 +: 256],
                     exp[bw*256 +: 256]);
        end
    endtask

    task automatic model_a(input logic [1:0] md, input logic [255:0] cn, input logic [255:0] mm,
                           input logic [PKA-1:0] pk, input logic [SKA-1:0] sk, input logic [CA-1:0] c);
        case (md)
            KG: begin
                e_m = mm;
                e_c = c;
                for (int i = 0; i <= 12 * KA; i++) e_pk[i*256 +: 256] = cn ^ 256'(i);
                for (int i = 0; i < 12 * KA; i++) e_sk[i*256 +: 256] = ~cn ^ 256'(i);
            end
            EN: begin
                e_pk = pk;
                e_sk = sk;
                e_m  = mm;
                for (int i = 0; i < DUA * KA + DVA; i++) e_c[i*256 +: 256] = mm ^ 256'(i);
            end
            DE: begin
                e_pk = pk;
                e_sk = sk;
                e_c  = c;
                e_m  = c[CA-1 -: 256];
            end
            default: ;
        endcase
    endtask

    task automatic check_outputs_a();
        chk_vec("pk_out", pk_out_a, e_pk, PKA / 256);
        chk_vec("sk_out", sk_out_a, e_sk, SKA / 256);
        chk_vec("c_out", c_out_a, e_c, CA / 256);
        chk256("m_out", m_out_a, e_m);
    endtask

    task automatic run_a(input logic [1:0] md, input logic [255:0] cn, input logic [255:0] mm,
                         input logic [255:0] ctop, input int exp_lat, input bit exp_err,
                         input bit hold, input bit scramble);
        logic [PKA-1:0] pk;
        logic [SKA-1:0] sk;
        logic [CA-1:0]  c;
        int cyc, nbusy, lat, extra;
        for (int i = 0; i < PKA / 256; i++) pk[i*256 +: 256] = rnd256();
        for (int i = 0; i < SKA / 256; i++) sk[i*256 +: 256] = rnd256();
        for (int i = 0; i < CA / 256; i++) c[i*256 +: 256] = rnd256();
        c[CA-1 -: 256] = ctop;
        @(negedge clk);
        mode_a = md; coin_a = cn; m_a = mm; pk_a = pk; sk_a = sk; c_a = c; start_a = 1'b1;
        model_a(md, cn, mm, pk, sk, c);
        @(posedge clk);
        #1;
        if (!hold) start_a = 1'b0;
        if (scramble) begin
            coin_a = rnd256(); m_a = rnd256(); pk_a = ~pk; sk_a = ~sk;
            if (md != DE) c_a = ~c;
        end
        chk_int("err_clear_on_accept", int'(err_a), 0);
        cyc = 0; nbusy = 0; lat = -1;
        while (lat < 0 && cyc <= 300) begin
            if (busy_a) nbusy++;
            if (done_a) lat = cyc;
            else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        start_a = 1'b0;
        chk_int("latency", lat, exp_lat);
        chk_int("busy_cycles", nbusy, exp_err ? 0 : exp_lat - 1);
        chk_int("err", int'(err_a), int'(exp_err));
        check_outputs_a();
        @(posedge clk);
        #1;
        chk_int("done_one_cycle", int'(done_a), 0);
        if (hold) begin
            extra = 0;
            repeat (40) begin
                @(posedge clk);
                #1;
                if (done_a || busy_a) extra++;
            end
            chk_int("start_not_queued", extra, 0);
        end
    endtask

    task automatic check_zero_a();
        chk_int("rst_busy", int'(busy_a), 0);
        chk_int("rst_done", int'(done_a), 0);
        chk_int("rst_err", int'(err_a), 0);
        e_pk = '0; e_sk = '0; e_c = '0; e_m = '0;
        check_outputs_a();
    endtask

    initial begin
        logic [CB-1:0] e_cb;
        logic [255:0]  mb;
        int cyc, nbusy, lat;
        rst_n = 1'b0;
        start_a = 1'b0; mode_a = 2'b00; coin_a = '0; m_a = '0; pk_a = '0; sk_a = '0; c_a = '0;
        start_b = 1'b0; mode_b = 2'b00; coin_b = '0; m_b = '0; pk_b = '0; sk_b = '0; c_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check_zero_a();
        @(negedge clk);
        rst_n = 1'b1;

        tbl[0] = '{KG, {32{8'hA5}}, 256'h1234, 256'h77, 30, 1'b0};
        tbl[1] = '{EN, 256'h5, 256'h1, 256'h88, 29, 1'b0};
        tbl[2] = '{DE, 256'h9, 256'h3, 256'hDEAD, 6, 1'b0};
        tbl[3] = '{IL, 256'hF, 256'h4, 256'h55, 1, 1'b1};
        tbl[4] = '{KG, 256'h0, 256'h6, 256'h66, 30, 1'b0};
        for (int i = 0; i < 5; i++) begin
            run_a(tbl[i].md, tbl[i].cn, tbl[i].mm, tbl[i].ctop, tbl[i].lat, tbl[i].err, 1'b0, 1'b0);
            case (i)
                0: begin
                    chk256("kg_pk_word24", pk_out_a[24*256 +: 256], {32{8'hA5}} ^ 256'd24);
                    chk256("kg_sk_word0", sk_out_a[255:0], ~{32{8'hA5}});
                end
                1: chk256("en_c_word23", c_out_a[23*256 +: 256], 256'h16);
                2: chk256("de_m_out", m_out_a, 256'hDEAD);
                default: ;
            endcase
        end

        // Randomised operations with inputs scrambled after acceptance.
        for (int r = 0; r < 12; r++) begin
            logic [1:0] md;
            md = 2'($urandom_range(0, 3));
            run_a(md, rnd256(), rnd256(), rnd256(), lat_a(md), md == IL, 1'b0, 1'b1);
        end

        // start held high for the whole keygen: exactly one done, nothing queued.
        run_a(KG, rnd256(), rnd256(), rnd256(), 30, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset in the middle of a keygen fill.
        @(negedge clk);
        mode_a = KG; coin_a = rnd256(); start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero_a();
        @(negedge clk);
        rst_n = 1'b1;
        run_a(DE, rnd256(), rnd256(), rnd256(), 6, 1'b0, 1'b0, 1'b1);

        // K=4, DU=11, DV=5, no extra latency: 49 encaps beats.
        mb = rnd256();
        @(negedge clk);
        for (int i = 0; i < PKB / 256; i++) pk_b[i*256 +: 256] = rnd256();
        for (int i = 0; i < SKB / 256; i++) sk_b[i*256 +: 256] = rnd256();
        for (int i = 0; i < CB / 256; i++) c_b[i*256 +: 256] = rnd256();
        mode_b = EN; m_b = mb; start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        m_b = rnd256();
        cyc = 0; nbusy = 0; lat = -1;
        while (lat < 0 && cyc <= 300) begin
            if (busy_b) nbusy++;
            if (done_b) lat = cyc;
            else begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        for (int i = 0; i < NB; i++) e_cb[i*256 +: 256] = mb ^ 256'(i);
        chk_int("b_latency", lat, 50);
        chk_int("b_busy_cycles", nbusy, 49);
        chk_int("b_err", int'(err_b), 0);
        chk_vec("b_c_out", c_out_b, e_cb, NB);
        chk_vec("b_pk_out", pk_out_b, pk_b, PKB / 256);
        chk_vec("b_sk_out", {256'd0, sk_out_b}, {256'd0, sk_b}, SKB / 256);
        chk256("b_m_out", m_out_b, mb);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
